// File: rtl/sdrc_bank_arb.sv
// rtl/sdrc_bank_arb.sv - round-robin arbiter of four bank FSM commands into xfr_ctl
// Optional ACT-to-ACT (tRRD) spacing is built when SDRC_TRRD_EN is defined.
module sdrc_bank_arb #(
   parameter int ID_W  = 4,
   parameter int LEN_W = 7
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [3:0]         b2x_req,
   input  logic [7:0]         b2x_cmd,
   input  logic [51:0]        b2x_addr,
   input  logic [4*LEN_W-1:0] b2x_len,
   input  logic [4*ID_W-1:0]  b2x_id,
   input  logic [3:0]         b2x_start,
   input  logic [3:0]         b2x_last,
   input  logic [3:0]         b2x_wrap,
   output logic [3:0]         x2b_ack,
   output logic               a2x_req,
   output logic [1:0]         a2x_ba,
   output logic [1:0]         a2x_cmd,
   output logic [12:0]        a2x_addr,
   output logic [LEN_W-1:0]   a2x_len,
   output logic [ID_W-1:0]    a2x_id,
   output logic               a2x_start,
   output logic               a2x_last,
   output logic               a2x_wrap,
   input  logic               x2a_ack,
   input  logic [3:0]         trrd_delay
);

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   arb_state_t state, next_state;
   logic [1:0] grant, next_grant;
   logic [1:0] rr_ptr, next_rr;
   logic [3:0] grant_oh;
   logic [3:0] other_req;
   logic       act_blk;
   logic       cmd_taken;

   // First set bit of req at or after ptr, wrapping; ptr itself when req is empty.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   assign grant_oh  = 4'b0001 << grant;
   assign other_req = b2x_req & ~grant_oh;
   assign cmd_taken = a2x_req & x2a_ack;

   // Command fields track the granted bank live, so a PRE->ACT switch is forwarded as-is.
   assign a2x_ba    = grant;
   assign a2x_cmd   = b2x_cmd[2*grant +: 2];
   assign a2x_addr  = b2x_addr[13*grant +: 13];
   assign a2x_len   = b2x_len[LEN_W*grant +: LEN_W];
   assign a2x_id    = b2x_id[ID_W*grant +: ID_W];
   assign a2x_start = b2x_start[grant];
   assign a2x_last  = b2x_last[grant];
   assign a2x_wrap  = b2x_wrap[grant];

`ifdef SDRC_TRRD_EN
   localparam logic [1:0] OP_ACT = 2'b01;
   logic [3:0] trrd_cntr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         trrd_cntr <= 4'd0;
      else if (cmd_taken && a2x_cmd == OP_ACT)
         trrd_cntr <= trrd_delay;
      else if (trrd_cntr != 4'd0)
         trrd_cntr <= trrd_cntr - 4'd1;
   end

   assign act_blk = (a2x_cmd == OP_ACT) && (trrd_cntr != 4'd0);
`else
   logic unused_trrd;
   assign unused_trrd = ^trrd_delay;
   assign act_blk     = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ARB_IDLE;
         grant  <= 2'd0;
         rr_ptr <= 2'd0;
      end else begin
         state  <= next_state;
         grant  <= next_grant;
         rr_ptr <= next_rr;
      end
   end

   always_comb begin
      next_state = state;
      next_grant = grant;
      next_rr    = rr_ptr;
      a2x_req    = 1'b0;
      x2b_ack    = 4'b0000;
      case (state)
         ARB_IDLE: begin
            if (|b2x_req) begin
               next_grant = rr_pick(b2x_req, rr_ptr);
               next_state = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            a2x_req = b2x_req[grant] & ~act_blk;
            if (a2x_req && x2a_ack) begin
               x2b_ack = grant_oh;
               next_rr = grant + 2'd1;
               // Chain straight into the next requester so back-to-back commands have no bubble.
               if (|other_req)
                  next_grant = rr_pick(other_req, grant + 2'd1);
               else
                  next_state = ARB_IDLE;
            end else if (!b2x_req[grant]) begin
               next_state = ARB_IDLE;
            end
         end
         default: next_state = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// tb/tb_sdrc_bank_arb.sv - scoreboard bench for sdrc_bank_arb
// Expected acks are queued by the stimulus; a negedge monitor pops them as x2b_ack fires.
module tb_sdrc_bank_arb;
   localparam int ID_W  = 4;
   localparam int LEN_W = 7;
   localparam logic [1:0] OP_PRE = 2'b00, OP_ACT = 2'b01, OP_RD = 2'b10, OP_WR = 2'b11;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [3:0]         b2x_req;
   logic [7:0]         b2x_cmd;
   logic [51:0]        b2x_addr;
   logic [4*LEN_W-1:0] b2x_len;
   logic [4*ID_W-1:0]  b2x_id;
   logic [3:0]         b2x_start, b2x_last, b2x_wrap;
   logic [3:0]         x2b_ack;
   logic               a2x_req;
   logic [1:0]         a2x_ba, a2x_cmd;
   logic [12:0]        a2x_addr;
   logic [LEN_W-1:0]   a2x_len;
   logic [ID_W-1:0]    a2x_id;
   logic               a2x_start, a2x_last, a2x_wrap;
   logic               x2a_ack;
   logic [3:0]         trrd_delay;

   sdrc_bank_arb #(.ID_W(ID_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .b2x_req(b2x_req), .b2x_cmd(b2x_cmd), .b2x_addr(b2x_addr),
      .b2x_len(b2x_len), .b2x_id(b2x_id), .b2x_start(b2x_start),
      .b2x_last(b2x_last), .b2x_wrap(b2x_wrap), .x2b_ack(x2b_ack),
      .a2x_req(a2x_req), .a2x_ba(a2x_ba), .a2x_cmd(a2x_cmd),
      .a2x_addr(a2x_addr), .a2x_len(a2x_len), .a2x_id(a2x_id),
      .a2x_start(a2x_start), .a2x_last(a2x_last), .a2x_wrap(a2x_wrap),
      .x2a_ack(x2a_ack), .trrd_delay(trrd_delay)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         bank;
      logic [1:0] cmd;
      int         at;
   } exp_t;
   exp_t sb[$];

   int         rem [4];
   logic [3:0] ack_s;

   function automatic logic [12:0] addr_of(int b);
      return 13'h1000 | 13'(b * 'h111);
   endfunction
   function automatic logic [ID_W-1:0] id_of(int b);
      return ID_W'(b + 5);
   endfunction
   function automatic logic [LEN_W-1:0] len_of(int b);
      return LEN_W'(8 * b + 3);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ack(input int bank, input logic [1:0] cmd, input int at);
      exp_t e;
      e.bank = bank;
      e.cmd  = cmd;
      e.at   = at;
      sb.push_back(e);
   endtask

   // Bank model: a bank drops its request once its last queued command is acked.
   task automatic tick();
      @(negedge clk);
      ack_s = x2b_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (ack_s[i] && rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) b2x_req[i] = 1'b0;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_bank(input int b, input logic [1:0] cmd, input int n);
      b2x_cmd[2*b +: 2] = cmd;
      rem[b]            = n;
      b2x_req[b]        = (n != 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (x2b_ack != 4'b0000) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack x2b_ack=%b a2x_ba=%0d at cyc %0d", x2b_ack, a2x_ba, cyc);
         end else begin
            e = sb.pop_front();
            chk("ack_fields",
                {a2x_req, x2b_ack, a2x_ba, a2x_cmd, a2x_addr, a2x_id, a2x_len},
                {1'b1, 4'b0001 << e.bank, 2'(e.bank), e.cmd, addr_of(e.bank), id_of(e.bank), len_of(e.bank)});
            chk("ack_cycle", 64'(cyc), 64'(e.at));
         end
      end
   end

   int c0;

   initial begin
      reset_n    = 1'b0;
      x2a_ack    = 1'b0;
      trrd_delay = 4'd3;
      b2x_req    = '0;
      b2x_cmd    = '0;
      b2x_start  = 4'b0101;
      b2x_last   = 4'b0011;
      b2x_wrap   = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         rem[i]               = 0;
         b2x_addr[13*i +: 13] = addr_of(i);
         b2x_id[ID_W*i +: ID_W]   = id_of(i);
         b2x_len[LEN_W*i +: LEN_W] = len_of(i);
      end
      #12;
      chk("reset_a2x_req", a2x_req, 0);
      chk("reset_x2b_ack", x2b_ack, 0);
      chk("reset_a2x_ba", a2x_ba, 0);
      chk("reset_mux_bank0", a2x_addr, addr_of(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();

      // Round-robin with every bank requesting and ack held high.
      x2a_ack = 1'b1;
      set_bank(0, OP_RD, 2);
      set_bank(1, OP_WR, 1);
      set_bank(2, OP_RD, 1);
      set_bank(3, OP_WR, 1);
      c0 = cyc;
      expect_ack(0, OP_RD, c0 + 1);
      expect_ack(1, OP_WR, c0 + 2);
      expect_ack(2, OP_RD, c0 + 3);
      expect_ack(3, OP_WR, c0 + 4);
      expect_ack(0, OP_RD, c0 + 5);
      ticks(8);

      // Granted bank 1 withdraws before ack; bank 3 wins after an idle cycle.
      x2a_ack = 1'b0;
      set_bank(1, OP_RD, 1);
      set_bank(3, OP_WR, 1);
      c0 = cyc;
      tick();
      chk("drop_grant_ba", a2x_ba, 1);
      chk("drop_grant_req", a2x_req, 1);
      b2x_req[1] = 1'b0;
      rem[1]     = 0;
      #1;
      chk("drop_req_low", a2x_req, 0);
      tick();
      chk("drop_idle_req", a2x_req, 0);
      tick();
      chk("drop_regrant_ba", a2x_ba, 3);
      chk("drop_regrant_req", a2x_req, 1);
      x2a_ack = 1'b1;
      expect_ack(3, OP_WR, c0 + 3);
      ticks(3);

      // Single request, one clock of latency.
      set_bank(2, OP_RD, 1);
      c0 = cyc;
      chk("single_idle_req", a2x_req, 0);
      expect_ack(2, OP_RD, c0 + 1);
      ticks(4);

      // Live command change while granted and unacked.
      x2a_ack = 1'b0;
      set_bank(2, OP_PRE, 1);
      c0 = cyc;
      tick();
      chk("live_pre_cmd", a2x_cmd, OP_PRE);
      b2x_cmd[5:4] = OP_ACT;
      #1;
      chk("live_act_cmd", a2x_cmd, OP_ACT);
      tick();
      x2a_ack = 1'b1;
      expect_ack(2, OP_ACT, c0 + 2);
      ticks(7);

      // Two ACTs back to back: second is spaced by tRRD when enabled.
      set_bank(0, OP_ACT, 1);
      set_bank(1, OP_ACT, 1);
      c0 = cyc;
      expect_ack(0, OP_ACT, c0 + 1);
`ifdef SDRC_TRRD_EN
      expect_ack(1, OP_ACT, c0 + 5);
`else
      expect_ack(1, OP_ACT, c0 + 2);
`endif
      ticks(2);
`ifdef SDRC_TRRD_EN
      chk("trrd_second_act_req", a2x_req, 0);
`else
      chk("trrd_second_act_req", a2x_req, 1);
`endif
      ticks(6);

      // Reset mid-grant with ack high; after release bank 0 wins over bank 2.
      set_bank(3, OP_RD, 1);
      tick();
      #1;
      reset_n = 1'b0;
      #1;
      chk("midreset_a2x_req", a2x_req, 0);
      chk("midreset_x2b_ack", x2b_ack, 0);
      set_bank(3, OP_RD, 0);
      set_bank(0, OP_RD, 1);
      set_bank(2, OP_WR, 1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      c0 = cyc;
      expect_ack(0, OP_RD, c0 + 1);
      expect_ack(2, OP_WR, c0 + 2);
      ticks(5);

      chk("scoreboard_drained", 64'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
